conv_window_gen: RTL and testbench

- Consumer end of the pixel delay-line path in the convolution datapath.
- Accepts a raster-order pixel stream with a valid qualifier and keeps two row-length line buffers, built as enable-gated shift chains.
- Assembles a 3x3 pixel window for the downstream MAC array.
- Flags each window position that lies fully inside the frame, and flags the end of each frame.

---
 rtl/conv_window_gen_pkg.sv | 15 +
 rtl/conv_window_gen_line_buffer.sv | 35 +++
 rtl/conv_window_gen.sv | 99 +++++++++
 tb/tb_conv_window_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared constants for the 3x3 convolution window generator.
// Tap k = KSZ*i + j, where i is the row (0 = oldest) and j is the column (0 = oldest).
package conv_window_gen_pkg;

  localparam int unsigned KSZ        = 3;
  localparam int unsigned KTAPS      = KSZ * KSZ;
  localparam int unsigned D_DEFAULT  = 16;

  localparam int unsigned TAP_CENTRE = 4;
  localparam int unsigned TAP_TL     = 0;
  localparam int unsigned TAP_TR     = 2;
  localparam int unsigned TAP_BL     = 6;
  localparam int unsigned TAP_BR     = 8;

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// Enable-gated shift chain that delays a pixel stream by DEPTH accepted pixels.
// The output is the oldest stage of the chain, so it is registered.
module line_buffer #(
  parameter int unsigned D     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [D-1:0] i_data,
  output logic [D-1:0] o_data
);

  logic [DEPTH-1:0][D-1:0] chain_q;
  logic [DEPTH-1:0][D-1:0] chain_d;

  // Stage 0 takes the new pixel; the highest stage is the oldest.
  always_comb begin
    chain_d = chain_q;
    if (i_en) begin
      chain_d = {chain_q[DEPTH-2:0], i_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign o_data = chain_q[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator over a raster pixel stream, with in-frame
// window qualification and an end-of-frame pulse.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int unsigned D = D_DEFAULT,
  parameter int unsigned W = 8,
  parameter int unsigned H = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [D-1:0]       i_data,
  output logic               o_valid,
  output logic [KTAPS*D-1:0] o_win,
  output logic               o_frame_done
);

  localparam int unsigned CW = $clog2(W);
  localparam int unsigned RW = $clog2(H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic [KSZ-1:0][KSZ-1:0][D-1:0] win_q, win_d;
  logic [KSZ-1:0][D-1:0]          col_in;

  logic [D-1:0] lb0_out;
  logic [D-1:0] lb1_out;

  logic last_col;
  logic last_row;

  line_buffer #(.D(D), .DEPTH(W)) u_lb0 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_valid),
    .i_data  (i_data),
    .o_data  (lb0_out)
  );

  line_buffer #(.D(D), .DEPTH(W)) u_lb1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_valid),
    .i_data  (lb0_out),
    .o_data  (lb1_out)
  );

  // Incoming column: row 0 is two rows up, row 2 is the current row.
  assign col_in = {i_data, lb0_out, lb1_out};

  assign last_col = (col_q == CW'(W - 1));
  assign last_row = (row_q == RW'(H - 1));

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (i_valid) begin
      col_d = last_col ? '0 : col_q + CW'(1);
      if (last_col) begin
        row_d = last_row ? '0 : row_q + RW'(1);
      end
      for (int i = 0; i < KSZ; i++) begin
        win_d[i] = {col_in[i], win_q[i][KSZ-1:1]};
      end
      // Only windows lying fully inside the frame are flagged.
      valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
      done_d  = last_col && last_row;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Packed [i][j] flattening places tap 3*i+j at bits D*(3*i+j).
  assign o_win        = win_q;
  assign o_valid      = valid_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized and directed bench for conv_window_gen (W=4, H=4, D=16) against a
// stream-history reference model.
module tb_conv_window_gen;

  localparam int unsigned D  = 16;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned WW = 9 * D;

  logic          clk;
  logic          i_rst_n;
  logic          i_valid;
  logic [D-1:0]  i_data;
  logic          o_valid;
  logic [WW-1:0] o_win;
  logic          o_frame_done;

  int n_checks;
  int n_errors;

  // Model state: every pixel accepted since reset, in arrival order.
  logic [D-1:0]  hist[$];
  logic          exp_valid;
  logic          exp_done;
  logic [WW-1:0] exp_win;

  int           n_valid;
  int           n_done;
  int           n_consec;
  logic         prev_valid;
  logic [D-1:0] centres[$];

  conv_window_gen #(.D(D), .W(W), .H(H)) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .o_win        (o_win),
    .o_frame_done (o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] pack9(input int unsigned t[9]);
    logic [WW-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r[D*k +: D] = D'(t[k]);
    return r;
  endfunction

  // A pixel at stream position n lands in frame cell (n%(W*H)); tap (i,j)
  // of its window is the pixel (2-i) rows and (2-j) columns earlier.
  task automatic model_accept(input logic [D-1:0] d);
    int n, pos, r, c, idx;
    hist.push_back(d);
    n   = hist.size() - 1;
    pos = n % (W * H);
    r   = pos / W;
    c   = pos % W;
    exp_valid = (r >= 2) && (c >= 2);
    exp_done  = (pos == W * H - 1);
    for (int k = 0; k < 9; k++) begin
      idx = n - (2 - k / 3) * W - (2 - k % 3);
      exp_win[D*k +: D] = (idx >= 0) ? hist[idx] : '0;
    end
  endtask

  task automatic cycle(input logic v, input logic [D-1:0] d);
    i_valid = v;
    i_data  = d;
    @(posedge clk);
    if (!i_rst_n) begin
      hist.delete();
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      exp_win   = '0;
    end else if (v) begin
      model_accept(d);
    end else begin
      exp_valid = 1'b0;
      exp_done  = 1'b0;
    end
    #1;
    check("valid", WW'(o_valid), WW'(exp_valid));
    check("frame_done", WW'(o_frame_done), WW'(exp_done));
    check("win", o_win, exp_win);
    if (o_valid) begin
      n_valid++;
      centres.push_back(o_win[D*4 +: D]);
    end
    if (o_frame_done) n_done++;
    if (o_valid && prev_valid) n_consec++;
    prev_valid = o_valid;
  endtask

  task automatic clear_stats();
    n_valid    = 0;
    n_done     = 0;
    n_consec   = 0;
    prev_valid = 1'b0;
    centres.delete();
  endtask

  task automatic check_centres(input string tag);
    int unsigned ref_c[4];
    ref_c = '{5, 6, 9, 10};
    check({tag, "_count"}, WW'(centres.size()), WW'(4));
    for (int k = 0; k < 4 && k < centres.size(); k++)
      check({tag, "_centre"}, WW'(centres[k]), WW'(ref_c[k]));
  endtask

  // One full frame with pixel = 4*r + c, plus directed checks at key pixels.
  task automatic frame_ramp(input string tag);
    for (int v = 0; v < W * H; v++) begin
      cycle(1'b1, D'(v));
      if (v == 10) begin
        check({tag, "_first_valid"}, WW'(o_valid), WW'(1));
        check({tag, "_first_win"}, o_win, pack9('{0, 1, 2, 4, 5, 6, 8, 9, 10}));
      end
      if (v == 12 || v == 13) check({tag, "_rowbound_valid"}, WW'(o_valid), WW'(0));
      if (v == 14) check({tag, "_row3_win"}, o_win, pack9('{4, 5, 6, 8, 9, 10, 12, 13, 14}));
      if (v == 15) begin
        check({tag, "_done"}, WW'(o_frame_done), WW'(1));
        check({tag, "_last_win"}, o_win, pack9('{5, 6, 7, 9, 10, 11, 13, 14, 15}));
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_win   = '0;
    i_rst_n   = 1'b0;
    i_valid   = 1'b0;
    i_data    = '0;
    clear_stats();

    cycle(1'b0, '0);
    cycle(1'b1, 16'h1234);
    check("rst_valid", WW'(o_valid), WW'(0));
    check("rst_win", o_win, '0);
    i_rst_n = 1'b1;

    // Continuous frame
    clear_stats();
    frame_ramp("cont");
    check_centres("cont");
    check("cont_done_count", WW'(n_done), WW'(1));

    // Every other cycle idle
    clear_stats();
    for (int v = 0; v < W * H; v++) begin
      cycle(1'b1, D'(v));
      cycle(1'b0, D'($urandom));
    end
    check_centres("gap");
    check("gap_consec", WW'(n_consec), WW'(0));

    // Back-to-back frames
    clear_stats();
    frame_ramp("b2b0");
    frame_ramp("b2b1");
    check("b2b_valid_count", WW'(n_valid), WW'(8));
    check("b2b_done_count", WW'(n_done), WW'(2));

    // Reset mid-frame, with i_valid held high through the reset cycle
    for (int v = 0; v < 10; v++) cycle(1'b1, D'(v));
    i_rst_n = 1'b0;
    cycle(1'b1, D'($urandom));
    i_rst_n = 1'b1;
    check("midrst_valid", WW'(o_valid), WW'(0));
    check("midrst_done", WW'(o_frame_done), WW'(0));
    check("midrst_win", o_win, '0);
    clear_stats();
    frame_ramp("post_rst");
    check_centres("post_rst");

    // Data extremes
    for (int v = 0; v < W * H; v++) cycle(1'b1, 16'hFFFF);
    check("ones_win", o_win, {WW{1'b1}});
    check("ones_done", WW'(o_frame_done), WW'(1));
    for (int v = 0; v < W * H; v++) cycle(1'b1, 16'h0000);
    check("zeros_win", o_win, '0);

    // Random data and random gaps across many frames
    clear_stats();
    for (int n = 0; n < 400; n++) cycle(1'($urandom_range(0, 2) != 0), D'($urandom));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
